cmoving_avg_ctrl: RTL and testbench
===================================

// Module: cmoving_avg_ctrl
// PURPOSE
// Sequencer for a complex moving-average datapath (I/Q moving_sum + round/clip pair). Owns window length, clear pulse,
// warm-up discard and burst framing: upstream IQ is gated into the averager; its outputs are dropped until the window is full,
// then NUM_OUT averages are forwarded with out_tlast on the last. Sits between the settings bus and the averager in the DSP chain.
// PARAMETERS
// DATA_WIDTH  16    I and Q sample width
// MAX_LEN     2047  largest window length supported by the datapath
// SR_BASE     0     settings-bus base address; regs: +0 LEN, +1 NUM_OUT, +2 CTRL (bit0 start, bit1 stop, bit2 continuous)
// PORTS
// clk           in   1              clock
// reset_n       in   1              async active-low reset
// set_stb       in   1              settings write strobe
// set_addr      in   8              settings address
// set_data      in   32             settings data
// in_tvalid/in_tready  in/out 1     upstream handshake; in_itdata, in_qtdata in DATA_WIDTH each
// avg_tvalid/avg_tready out/in 1    to averager; avg_itdata, avg_qtdata out DATA_WIDTH each (in data, registered)
// avg_len       out  clog2(MAX_LEN+1)  window length to averager
// avg_clear     out  1              clear pulse to averager
// res_tvalid/res_tready in/out 1    from averager; res_itdata, res_qtdata in DATA_WIDTH each
// out_tvalid/out_tready/out_tlast out/in/out 1  downstream; out_itdata, out_qtdata out DATA_WIDTH each
// busy          out  1              high in any state except IDLE
// BEHAVIOUR
// - Reset: state IDLE; avg_len=MAX_LEN-1; NUM_OUT reg=1; all tvalid, tready, out_tlast, avg_clear, busy = 0; counters 0.
// - LEN writes clamp to [1,MAX_LEN]; LEN/NUM_OUT writes while busy are held and applied at next entry to CLEAR. NUM_OUT=0 treated as 1.
// - States: IDLE -start-> CLEAR (avg_clear=1 exactly 2 cycles, in_tready=0, res_tready=1 to flush) -> FILL -> RUN.
// - FILL: in->avg skid-buffered, 1-cycle latency, full AXI rules (valid held until ready, data stable). res_tready=1, results
//   discarded; fill_cnt counts accepted res beats; at fill_cnt==LEN-1 on an accepted beat -> RUN (first LEN-1 results dropped).
// - RUN: res forwarded to out combinationally (out_tvalid=res_tvalid, res_tready=out_tready); out_cnt counts out beats;
//   out_tlast=1 when out_cnt==NUM_OUT-1. On that handshake: continuous=1 -> RUN with out_cnt=0 (no refill); else -> DRAIN.
// - DRAIN: in_tready=0, res_tready=1 discarding, until avg path idle (no valid for 4 cycles) -> IDLE.
// - stop bit: any state -> DRAIN at next cycle boundary; never truncates an in-flight out beat (waits for its handshake);
//   out_tlast is NOT forced on stop.
// - start while busy ignored; start and stop in same write: stop wins.
// - Upstream never stalled in RUN except by backpressure; in_tready = avg skid not full and state in {FILL,RUN}.
// - Counters width clog2(MAX_LEN+1); out_cnt 32-bit, wrap not possible (bounded by NUM_OUT).
// - reset_n asserted mid-burst: immediate return to reset values; partial bursts lost, no tlast.
// CONFIGURATION
// CMOVING_AVG_CTRL_STATS_EN defined: adds ports drop_cnt out 32 (results discarded in FILL/DRAIN, saturating) and
//   burst_cnt out 16 (bursts completed with tlast, wraps); both cleared by reset_n and on CLEAR entry (drop_cnt only).
// Not defined: ports absent, no counter logic; all other behaviour identical.
// TESTING
// 1 Reset: hold reset_n=0 -> all outputs 0, avg_len=2046 (MAX_LEN 2047); release -> remains IDLE, busy=0.
// 2 LEN=4, NUM_OUT=8, start, ramp input, res ready always -> avg_clear high 2 cycles, 3 results dropped, 8 out beats, tlast on 8th, IDLE.
// 3 Same as 2 with out_tready toggling 50% random -> same 8 values in order, no loss/dup, tlast only on beat 8.
// 4 Continuous=1, LEN=2, NUM_OUT=3, 9 outputs consumed -> tlast on beats 3,6,9; avg_clear only once.
// 5 stop asserted while out_tvalid&&!out_tready -> that beat completes, then DRAIN, IDLE; no further out_tvalid; LEN=0 write reads back as 1.
// 6 STATS_EN: scenario 2 -> drop_cnt=3 (+drain drops), burst_cnt=1; reset_n pulse mid-RUN -> counters 0, out_tvalid=0 same cycle.

Source files
------------

// File: rtl/cmoving_avg_ctrl.sv
// cmoving_avg_ctrl: sequencer for a complex (I/Q) moving-average datapath.
//
// Owns the window length, the averager clear pulse, warm-up discard and output
// burst framing. Upstream IQ is gated into the averager through a two-entry
// skid buffer. The first LEN-1 averager results are dropped. NUM_OUT results
// are then forwarded, with out_tlast_o on the last one.
//
// Settings registers (offset from SrBase):
//   +0 LEN      window length, clamped to [1, MaxLen]
//   +1 NUM_OUT  beats per burst, 0 treated as 1
//   +2 CTRL     bit0 start, bit1 stop (wins over start), bit2 continuous
// A LEN or NUM_OUT write made while busy is held and takes effect on the next
// entry to CLEAR. A write made while idle takes effect at once.
//
// Ports:
//   clk_i, reset_ni                   clock, async active-low reset
//   set_stb_i/set_addr_i/set_data_i   settings bus
//   in_*                              upstream IQ stream (AXI-style)
//   avg_*                             stream into averager, window length, clear
//   res_*                             result stream from averager
//   out_*                             downstream burst stream with tlast
//   busy_o                            high in any state except IDLE
//
// Optional feature (define CMOVING_AVG_CTRL_STATS_EN):
//   drop_cnt_o   results discarded in FILL/DRAIN, saturating, cleared on CLEAR entry
//   burst_cnt_o  bursts completed with tlast, wrapping
module cmoving_avg_ctrl #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned MaxLen    = 2047,
  parameter int unsigned SrBase    = 0,
  parameter int unsigned LenW      = $clog2(MaxLen + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 set_stb_i,
  input  logic [7:0]           set_addr_i,
  input  logic [31:0]          set_data_i,
  input  logic                 in_tvalid_i,
  output logic                 in_tready_o,
  input  logic [DataWidth-1:0] in_itdata_i,
  input  logic [DataWidth-1:0] in_qtdata_i,
  output logic                 avg_tvalid_o,
  input  logic                 avg_tready_i,
  output logic [DataWidth-1:0] avg_itdata_o,
  output logic [DataWidth-1:0] avg_qtdata_o,
  output logic [LenW-1:0]      avg_len_o,
  output logic                 avg_clear_o,
  input  logic                 res_tvalid_i,
  output logic                 res_tready_o,
  input  logic [DataWidth-1:0] res_itdata_i,
  input  logic [DataWidth-1:0] res_qtdata_i,
  output logic                 out_tvalid_o,
  input  logic                 out_tready_i,
  output logic                 out_tlast_o,
  output logic [DataWidth-1:0] out_itdata_o,
  output logic [DataWidth-1:0] out_qtdata_o,
  output logic                 busy_o
`ifdef CMOVING_AVG_CTRL_STATS_EN
  ,
  output logic [31:0]          drop_cnt_o,
  output logic [15:0]          burst_cnt_o
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StFill  = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam logic [7:0] AddrLen  = 8'(SrBase);
  localparam logic [7:0] AddrNum  = 8'(SrBase + 1);
  localparam logic [7:0] AddrCtrl = 8'(SrBase + 2);

  logic [2:0]      state_q, state_d;
  logic [LenW-1:0] len_q, len_d, len_sh_q, len_sh_d;
  logic [31:0]     num_q, num_d, num_sh_q, num_sh_d;
  logic            cont_q, cont_d;
  logic            stop_pend_q, stop_pend_d;
  logic            clr_cnt_q, clr_cnt_d;
  logic [LenW-1:0] fill_cnt_q, fill_cnt_d;
  logic [31:0]     out_cnt_q, out_cnt_d;
  logic [2:0]      idle_cnt_q, idle_cnt_d;

  // Skid buffer: output register plus one overflow slot.
  logic                 avg_valid_q, avg_valid_d, skid_valid_q, skid_valid_d;
  logic [DataWidth-1:0] avg_i_q, avg_i_d, avg_q_q, avg_q_d;
  logic [DataWidth-1:0] skid_i_q, skid_i_d, skid_q_q, skid_q_d;

  logic            wr_len, wr_num, wr_ctrl, start_req, stop_wr, stop_req;
  logic [LenW-1:0] len_wr_val;
  logic [31:0]     num_wr_val;
  logic            run, out_hs, res_hs, is_last, last_hs, push, pop, any_valid;
  logic            enter_clear, enter_drain;

  assign wr_len    = set_stb_i && (set_addr_i == AddrLen);
  assign wr_num    = set_stb_i && (set_addr_i == AddrNum);
  assign wr_ctrl   = set_stb_i && (set_addr_i == AddrCtrl);
  assign stop_wr   = wr_ctrl && set_data_i[1];
  assign start_req = wr_ctrl && set_data_i[0] && !set_data_i[1];
  assign stop_req  = stop_wr || stop_pend_q;

  always_comb begin
    if (set_data_i == 32'd0) begin
      len_wr_val = LenW'(1);
    end else if (set_data_i > 32'(MaxLen)) begin
      len_wr_val = LenW'(MaxLen);
    end else begin
      len_wr_val = set_data_i[LenW-1:0];
    end
  end

  assign num_wr_val = (set_data_i == 32'd0) ? 32'd1 : set_data_i;

  assign busy_o      = (state_q != StIdle);
  assign run         = (state_q == StRun);
  assign avg_len_o   = len_q;
  assign avg_clear_o = (state_q == StClear);
  assign in_tready_o = !skid_valid_q && ((state_q == StFill) || run);

  // In RUN the result stream passes straight through to the output.
  assign out_tvalid_o = run && res_tvalid_i;
  assign is_last      = (out_cnt_q == num_q - 32'd1);
  assign out_tlast_o  = run && is_last;
  assign out_itdata_o = res_itdata_i;
  assign out_qtdata_o = res_qtdata_i;
  assign res_tready_o = run ? out_tready_i
                            : ((state_q == StClear) || (state_q == StFill) ||
                               (state_q == StDrain));

  assign out_hs    = out_tvalid_o && out_tready_i;
  assign last_hs   = out_hs && is_last;
  assign res_hs    = res_tvalid_i && res_tready_o;
  assign push      = in_tvalid_i && in_tready_o;
  assign pop       = avg_valid_q && avg_tready_i;
  assign any_valid = avg_valid_q || res_tvalid_i;

  assign avg_tvalid_o = avg_valid_q;
  assign avg_itdata_o = avg_i_q;
  assign avg_qtdata_o = avg_q_q;

  always_comb begin
    avg_valid_d  = avg_valid_q;
    avg_i_d      = avg_i_q;
    avg_q_d      = avg_q_q;
    skid_valid_d = skid_valid_q;
    skid_i_d     = skid_i_q;
    skid_q_d     = skid_q_q;
    if (!avg_valid_q || pop) begin
      // Output slot frees up: refill from skid first to keep ordering.
      if (skid_valid_q) begin
        avg_valid_d  = 1'b1;
        avg_i_d      = skid_i_q;
        avg_q_d      = skid_q_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        avg_valid_d = 1'b1;
        avg_i_d     = in_itdata_i;
        avg_q_d     = in_qtdata_i;
      end else begin
        avg_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_i_d     = in_itdata_i;
      skid_q_d     = in_qtdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    len_sh_d    = len_sh_q;
    num_d       = num_q;
    num_sh_d    = num_sh_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q || stop_wr;
    clr_cnt_d   = clr_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    out_cnt_d   = out_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    enter_clear = 1'b0;
    enter_drain = 1'b0;

    if (wr_len) begin
      len_sh_d = len_wr_val;
      if (!busy_o) len_d = len_wr_val;
    end
    if (wr_num) begin
      num_sh_d = num_wr_val;
      if (!busy_o) num_d = num_wr_val;
    end
    if (wr_ctrl) cont_d = set_data_i[2];

    case (state_q)
      StIdle: begin
        if (stop_wr) begin
          enter_drain = 1'b1;
        end else if (start_req) begin
          enter_clear = 1'b1;
        end
      end
      StClear: begin
        if (stop_req) begin
          enter_drain = 1'b1;
        end else if (clr_cnt_q) begin
          // A window of one has no warm-up results to discard.
          state_d = (len_q == LenW'(1)) ? StRun : StFill;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      StFill: begin
        if (stop_req) begin
          enter_drain = 1'b1;
        end else if (res_hs) begin
          if (fill_cnt_q == len_q - LenW'(2)) begin
            state_d = StRun;
          end else begin
            fill_cnt_d = fill_cnt_q + LenW'(1);
          end
        end
      end
      StRun: begin
        // A presented beat must complete before a stop takes effect.
        if (out_hs) begin
          if (stop_req || (is_last && !cont_q)) begin
            enter_drain = 1'b1;
          end else if (is_last) begin
            out_cnt_d = 32'd0;
          end else begin
            out_cnt_d = out_cnt_q + 32'd1;
          end
        end else if (stop_req && !out_tvalid_o) begin
          enter_drain = 1'b1;
        end
      end
      StDrain: begin
        stop_pend_d = 1'b0;
        if (any_valid) begin
          idle_cnt_d = 3'd0;
        end else if (idle_cnt_q == 3'd3) begin
          state_d = StIdle;
        end else begin
          idle_cnt_d = idle_cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_clear) begin
      state_d    = StClear;
      len_d      = len_sh_q;
      num_d      = num_sh_q;
      clr_cnt_d  = 1'b0;
      fill_cnt_d = '0;
      out_cnt_d  = 32'd0;
    end
    if (enter_drain) begin
      state_d     = StDrain;
      idle_cnt_d  = 3'd0;
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      len_q        <= LenW'(MaxLen - 1);
      len_sh_q     <= LenW'(MaxLen - 1);
      num_q        <= 32'd1;
      num_sh_q     <= 32'd1;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      clr_cnt_q    <= 1'b0;
      fill_cnt_q   <= '0;
      out_cnt_q    <= 32'd0;
      idle_cnt_q   <= 3'd0;
      avg_valid_q  <= 1'b0;
      avg_i_q      <= '0;
      avg_q_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_i_q     <= '0;
      skid_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      len_sh_q     <= len_sh_d;
      num_q        <= num_d;
      num_sh_q     <= num_sh_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      out_cnt_q    <= out_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      avg_valid_q  <= avg_valid_d;
      avg_i_q      <= avg_i_d;
      avg_q_q      <= avg_q_d;
      skid_valid_q <= skid_valid_d;
      skid_i_q     <= skid_i_d;
      skid_q_q     <= skid_q_d;
    end
  end

`ifdef CMOVING_AVG_CTRL_STATS_EN
  logic [31:0] drop_cnt_q;
  logic [15:0] burst_cnt_q;
  logic        drop_inc;

  assign drop_inc = res_hs && ((state_q == StFill) || (state_q == StDrain));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drop_cnt_q  <= 32'd0;
      burst_cnt_q <= 16'd0;
    end else begin
      if (enter_clear) begin
        drop_cnt_q <= 32'd0;
      end else if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
      if (last_hs) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign burst_cnt_o = burst_cnt_q;
`endif

endmodule

// File: tb/tb_cmoving_avg_ctrl.sv
// Self-checking bench for cmoving_avg_ctrl. A behavioural averager stub feeds
// results back. Output beats are compared to window averages taken over the
// list of accepted upstream samples.
module tb_cmoving_avg_ctrl;
  localparam int DW   = 16;
  localparam int LenW = 11;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            set_stb;
  logic [7:0]      set_addr;
  logic [31:0]     set_data;
  logic            in_tvalid, in_tready;
  logic [DW-1:0]   in_i, in_q;
  logic            avg_tvalid, avg_tready;
  logic [DW-1:0]   avg_i, avg_q;
  logic [LenW-1:0] avg_len;
  logic            avg_clear;
  logic            res_tvalid, res_tready;
  logic [DW-1:0]   res_i, res_q;
  logic            out_tvalid, out_tready, out_tlast;
  logic [DW-1:0]   out_i, out_q;
  logic            busy;
`ifdef CMOVING_AVG_CTRL_STATS_EN
  logic [31:0]     drop_cnt;
  logic [15:0]     burst_cnt;
`endif

  always #5 clk = ~clk;

  cmoving_avg_ctrl dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .set_stb_i    (set_stb),
    .set_addr_i   (set_addr),
    .set_data_i   (set_data),
    .in_tvalid_i  (in_tvalid),
    .in_tready_o  (in_tready),
    .in_itdata_i  (in_i),
    .in_qtdata_i  (in_q),
    .avg_tvalid_o (avg_tvalid),
    .avg_tready_i (avg_tready),
    .avg_itdata_o (avg_i),
    .avg_qtdata_o (avg_q),
    .avg_len_o    (avg_len),
    .avg_clear_o  (avg_clear),
    .res_tvalid_i (res_tvalid),
    .res_tready_o (res_tready),
    .res_itdata_i (res_i),
    .res_qtdata_i (res_q),
    .out_tvalid_o (out_tvalid),
    .out_tready_i (out_tready),
    .out_tlast_o  (out_tlast),
    .out_itdata_o (out_i),
    .out_qtdata_o (out_q),
    .busy_o       (busy)
`ifdef CMOVING_AVG_CTRL_STATS_EN
    ,
    .drop_cnt_o   (drop_cnt),
    .burst_cnt_o  (burst_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference and stub state.
  int          in_i_l[$], in_q_l[$];   // accepted upstream samples
  int          hist_i[$], hist_q[$];   // averager stub history
  logic [15:0] rq_i[$], rq_q[$];       // averager stub pending results
  int k, tlast_cnt, clr_cycles, drops, fill_drops, late_valid;
  int len_cur, num_cur;
  bit watch, src_en, rnd_valid, rnd_ready, rnd_avg, ready_fixed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int win_avg(input int q[$], input int s, input int len);
    int sum = 0;
    for (int i = 0; i < len; i++) sum += q[s + i];
    return sum / len;
  endfunction

  task automatic reset_model();
    in_i_l.delete(); in_q_l.delete();
    k = 0; tlast_cnt = 0; clr_cycles = 0; drops = 0; fill_drops = -1;
    late_valid = 0; watch = 0;
  endtask

  // One clock: observe handshakes at negedge, drive new inputs just after posedge.
  task automatic step();
    bit in_hs, out_hs, res_hs;
    int ei, eq, n, l, cnt, si, sq;
    @(negedge clk);
    in_hs  = in_tvalid && in_tready;
    out_hs = out_tvalid && out_tready;
    res_hs = res_tvalid && res_tready;
    if (out_hs) begin
      if (k == 0) fill_drops = drops;
      if (in_i_l.size() >= k + len_cur) begin
        ei = win_avg(in_i_l, k, len_cur);
        eq = win_avg(in_q_l, k, len_cur);
      end else begin
        ei = -1;
        eq = -1;
      end
      check($sformatf("beat%0d_i", k), 32'(out_i), 32'(ei));
      check($sformatf("beat%0d_q", k), 32'(out_q), 32'(eq));
      check($sformatf("beat%0d_tlast", k), 32'(out_tlast), 32'(((k + 1) % num_cur) == 0));
      if (out_tlast) tlast_cnt++;
      k++;
    end
    if (res_hs) begin
      if (!out_hs) drops++;
      if (rq_i.size() > 0) begin
        void'(rq_i.pop_front());
        void'(rq_q.pop_front());
      end
    end
    if (watch && out_tvalid) late_valid++;
    if (avg_clear) begin
      clr_cycles++;
      hist_i.delete(); hist_q.delete(); rq_i.delete(); rq_q.delete();
    end
    if (avg_tvalid && avg_tready) begin
      hist_i.push_back(int'(avg_i));
      hist_q.push_back(int'(avg_q));
      n = hist_i.size();
      l = (int'(avg_len) == 0) ? 1 : int'(avg_len);
      cnt = (n < l) ? n : l;
      si = 0; sq = 0;
      for (int j = n - cnt; j < n; j++) begin
        si += hist_i[j];
        sq += hist_q[j];
      end
      rq_i.push_back(16'(si / l));
      rq_q.push_back(16'(sq / l));
    end
    if (in_hs) begin
      in_i_l.push_back(int'(in_i));
      in_q_l.push_back(int'(in_q));
    end
    @(posedge clk);
    #1;
    if (in_hs || !in_tvalid) begin
      in_tvalid = src_en && (!rnd_valid || ($urandom_range(0, 3) != 0));
      in_i = 16'($urandom_range(0, 4095));
      in_q = 16'($urandom_range(0, 4095));
    end
    avg_tready = rnd_avg ? ($urandom_range(0, 3) != 0) : 1'b1;
    res_tvalid = (rq_i.size() > 0);
    res_i = (rq_i.size() > 0) ? rq_i[0] : 16'd0;
    res_q = (rq_q.size() > 0) ? rq_q[0] : 16'd0;
    out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    step();
    set_stb = 1'b0;
  endtask

  task automatic run_until_beats(input int n, input int budget, input string tag);
    int c = 0;
    while (k < n && c < budget) begin
      step();
      c++;
    end
    check(tag, 32'(k), 32'(n));
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_tvalid = 1'b0; in_i = '0; in_q = '0; avg_tready = 1'b0;
    res_tvalid = 1'b0; res_i = '0; res_q = '0; out_tready = 1'b0;
    src_en = 0; rnd_valid = 0; rnd_ready = 0; rnd_avg = 0; ready_fixed = 1;
    len_cur = 1; num_cur = 1;
    reset_model();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_tready", 32'(in_tready), 32'd0);
    check("rst_avg_tvalid", 32'(avg_tvalid), 32'd0);
    check("rst_res_tready", 32'(res_tready), 32'd0);
    check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_out_tlast", 32'(out_tlast), 32'd0);
    check("rst_avg_clear", 32'(avg_clear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_avg_len", 32'(avg_len), 32'd2046);
    reset_n = 1'b1;
    src_en = 1;
    repeat (3) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_avg_len", 32'(avg_len), 32'd2046);

    // LEN=4, NUM_OUT=8, single burst, full-rate.
    reset_model(); len_cur = 4; num_cur = 8;
    wr(8'd0, 32'd4);
    wr(8'd1, 32'd8);
    check("s2_len_idle_write", 32'(avg_len), 32'd4);
    wr(8'd2, 32'd1);
    run_until_beats(8, 400, "s2_beats");
    watch = 1;
    run_until_idle(400, "s2_idle");
    check("s2_clear_cycles", 32'(clr_cycles), 32'd2);
    check("s2_fill_drops", 32'(fill_drops), 32'd3);
    check("s2_tlast_count", 32'(tlast_cnt), 32'd1);
    check("s2_late_valid", 32'(late_valid), 32'd0);
`ifdef CMOVING_AVG_CTRL_STATS_EN
    check("s2_drop_cnt", drop_cnt, 32'(drops));
    check("s2_burst_cnt", 32'(burst_cnt), 32'd1);
`endif

    // Same burst with random backpressure on every stream.
    reset_model(); rnd_ready = 1; rnd_avg = 1; rnd_valid = 1;
    wr(8'd2, 32'd1);
    run_until_beats(8, 1500, "s3_beats");
    watch = 1;
    run_until_idle(1500, "s3_idle");
    check("s3_clear_cycles", 32'(clr_cycles), 32'd2);
    check("s3_fill_drops", 32'(fill_drops), 32'd3);
    check("s3_tlast_count", 32'(tlast_cnt), 32'd1);
    check("s3_late_valid", 32'(late_valid), 32'd0);
    rnd_ready = 0; rnd_avg = 0; rnd_valid = 0;

    // Continuous: LEN=2, NUM_OUT=3; a LEN write mid-run must be held.
    reset_model(); len_cur = 2; num_cur = 3;
    wr(8'd0, 32'd2);
    wr(8'd1, 32'd3);
    wr(8'd2, 32'd5);
    run_until_beats(5, 400, "s4_beats5");
    wr(8'd0, 32'd3);
    check("s4_len_held", 32'(avg_len), 32'd2);
    run_until_beats(9, 400, "s4_beats9");
    check("s4_tlast_count", 32'(tlast_cnt), 32'd3);
    check("s4_clear_cycles", 32'(clr_cycles), 32'd2);
    wr(8'd2, 32'd2);
    run_until_idle(400, "s4_idle");

    // Stop while a beat is stalled: it must complete, then nothing more.
    reset_model(); len_cur = 3; num_cur = 100; ready_fixed = 0;
    wr(8'd1, 32'd100);
    wr(8'd2, 32'd1);
    for (int c = 0; c < 300 && out_tvalid !== 1'b1; c++) step();
    check("s5_valid_seen", 32'(out_tvalid), 32'd1);
    check("s5_len_applied", 32'(avg_len), 32'd3);
    wr(8'd2, 32'd2);
    repeat (3) step();
    check("s5_beat_held", 32'(out_tvalid), 32'd1);
    check("s5_still_busy", 32'(busy), 32'd1);
    ready_fixed = 1; out_tready = 1'b1;
    step();
    watch = 1;
    run_until_idle(3000, "s5_idle");
    check("s5_beats", 32'(k), 32'd1);
    check("s5_no_tlast", 32'(tlast_cnt), 32'd0);
    check("s5_late_valid", 32'(late_valid), 32'd0);
    wr(8'd0, 32'd0);
    check("len_clamp_low", 32'(avg_len), 32'd1);
    wr(8'd0, 32'd5000);
    check("len_clamp_high", 32'(avg_len), 32'd2047);

    // LEN=1 skips warm-up; NUM_OUT=0 behaves as 1.
    reset_model(); len_cur = 1; num_cur = 1;
    wr(8'd0, 32'd1);
    wr(8'd1, 32'd0);
    wr(8'd2, 32'd1);
    run_until_beats(1, 400, "s6_beats");
    watch = 1;
    run_until_idle(400, "s6_idle");
    check("s6_tlast_count", 32'(tlast_cnt), 32'd1);
    check("s6_fill_drops", 32'(fill_drops), 32'd0);
    check("s6_late_valid", 32'(late_valid), 32'd0);

    // Asynchronous reset mid-RUN.
    reset_model(); len_cur = 4; num_cur = 8;
    wr(8'd0, 32'd4);
    wr(8'd1, 32'd8);
    wr(8'd2, 32'd5);
    run_until_beats(3, 400, "s7_beats");
    reset_n = 1'b0;
    #1;
    check("s7_out_tvalid", 32'(out_tvalid), 32'd0);
    check("s7_busy", 32'(busy), 32'd0);
    check("s7_avg_tvalid", 32'(avg_tvalid), 32'd0);
    check("s7_in_tready", 32'(in_tready), 32'd0);
    check("s7_avg_len", 32'(avg_len), 32'd2046);
`ifdef CMOVING_AVG_CTRL_STATS_EN
    check("s7_drop_cnt", drop_cnt, 32'd0);
    check("s7_burst_cnt", 32'(burst_cnt), 32'd0);
`endif
    hist_i.delete(); hist_q.delete(); rq_i.delete(); rq_q.delete();
    res_tvalid = 1'b0; res_i = '0; res_q = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) step();
    check("s7_post_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
